uart_cmd_parser: RTL and testbench

Frames the byte stream from the UART receiver into validated 8-bit control commands for the image-processing stages (brightness, hue, grayscale and the splicing controls). It sits directly upstream of the image adjust stage. It drives that stage's `command_flag`, `ctrl_command_in` and `value_command_in` inputs, and returns a one-byte ACK/NAK to the UART transmitter. The block runs entirely in the `sys_clk` (50 MHz) domain.

---
 rtl/uart_cmd_parser.sv | 169 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames UART bytes (HEADER, cmd, chk) into control commands
// for the image adjust stage and queues a one-byte ACK/NAK reply.
module uart_cmd_parser #(
    parameter logic [7:0] HEADER         = 8'h55,
    parameter logic [7:0] CHK_KEY        = 8'hFF,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        command_flag,
    output logic [3:0]  ctrl_command_out,
    output logic [3:0]  value_command_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] frame_ok_cnt,
    output logic [7:0]  err_cnt
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_CMD = 2'd1,
        GET_CHK = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [7:0]      byte_q;
    logic            byte_v;
    logic [7:0]      cmd_r;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            issue;
    logic            nak;
    logic            tmo;

    assign to_hit = (to_cnt == TO_LAST);

    // Register the incoming byte so framing works off a clean, aligned copy.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q <= 8'h00;
            byte_v <= 1'b0;
        end else begin
            byte_q <= rx_data;
            byte_v <= rx_valid;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-cycle event decode (command, NAK, timeout).
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        nak     = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                if (byte_v && byte_q == HEADER) begin
                    state_n = GET_CMD;
                end
            end
            GET_CMD: begin
                if (byte_v) begin
                    state_n = GET_CHK;
                end else if (to_hit) begin
                    state_n = IDLE;
                    tmo     = 1'b1;
                end
            end
            GET_CHK: begin
                if (byte_v) begin
                    if (byte_q == (cmd_r ^ CHK_KEY)) begin
                        issue   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        nak     = 1'b1;
                        state_n = (byte_q == HEADER) ? GET_CMD : IDLE;
                    end
                end else if (to_hit) begin
                    state_n = IDLE;
                    tmo     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Latch the command byte of the frame in progress.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r <= 8'h00;
        end else if (state == GET_CMD && byte_v) begin
            cmd_r <= byte_q;
        end
    end

    // Inter-byte gap counter; idle outside a frame, restarted by every byte.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == IDLE || byte_v || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Command outputs: one-cycle flag, nibbles held until the next command.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            command_flag      <= 1'b0;
            ctrl_command_out  <= 4'h0;
            value_command_out <= 4'h0;
        end else begin
            command_flag <= issue;
            if (issue) begin
                ctrl_command_out  <= cmd_r[7:4];
                value_command_out <= cmd_r[3:0];
            end
        end
    end

    // Single-entry reply slot; a reply arriving while it is full is dropped.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else if (!tx_valid) begin
            if (issue || nak) begin
                tx_data  <= issue ? ACK_BYTE : NAK_BYTE;
                tx_valid <= 1'b1;
            end
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    // Frame statistics: good frames wrap, errors saturate.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok_cnt <= 16'h0000;
            err_cnt      <= 8'h00;
        end else begin
            if (issue) begin
                frame_ok_cnt <= frame_ok_cnt + 16'd1;
            end
            if ((nak || tmo) && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frames with hand-computed expectations
// for uart_cmd_parser, using a shortened inter-byte timeout.
module tb_uart_cmd_parser;

    localparam int TO = 64;

    logic        sys_clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        command_flag;
    logic [3:0]  ctrl_command_out;
    logic [3:0]  value_command_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] frame_ok_cnt;
    logic [7:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int flag_cnt    = 0;
    int base;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk          (sys_clk),
        .rst_n            (rst_n),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .command_flag     (command_flag),
        .ctrl_command_out (ctrl_command_out),
        .value_command_out(value_command_out),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .frame_ok_cnt     (frame_ok_cnt),
        .err_cnt          (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Count command pulses as seen between edges.
    always @(negedge sys_clk) begin
        if (command_flag === 1'b1) flag_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (command_flag !== 1'b0) begin miscompares++; $display("FAIL rst_flag got %h want 0", command_flag); end
        vectors++; if (ctrl_command_out !== 4'h0) begin miscompares++; $display("FAIL rst_ctrl got %h want 0", ctrl_command_out); end
        vectors++; if (value_command_out !== 4'h0) begin miscompares++; $display("FAIL rst_value got %h want 0", value_command_out); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_txd got %h want 00", tx_data); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_txv got %h want 0", tx_valid); end
        vectors++; if (frame_ok_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_ok got %0d want 0", frame_ok_cnt); end
        vectors++; if (err_cnt !== 8'h0) begin miscompares++; $display("FAIL rst_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_valid_frame();
        do_reset();
        send_byte(8'h55);
        send_byte(8'h75);
        send_byte(8'h8A);
        @(negedge sys_clk);
        vectors++; if (command_flag !== 1'b1) begin miscompares++; $display("FAIL vf_flag got %h want 1", command_flag); end
        vectors++; if (ctrl_command_out !== 4'h7) begin miscompares++; $display("FAIL vf_ctrl got %h want 7", ctrl_command_out); end
        vectors++; if (value_command_out !== 4'h5) begin miscompares++; $display("FAIL vf_value got %h want 5", value_command_out); end
        vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL vf_txv got %h want 1", tx_valid); end
        vectors++; if (tx_data !== 8'h06) begin miscompares++; $display("FAIL vf_txd got %h want 06", tx_data); end
        vectors++; if (frame_ok_cnt !== 16'd1) begin miscompares++; $display("FAIL vf_ok got %0d want 1", frame_ok_cnt); end
        @(negedge sys_clk);
        vectors++; if (command_flag !== 1'b0) begin miscompares++; $display("FAIL vf_pulse got %h want 0", command_flag); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL vf_txclr got %h want 0", tx_valid); end
        vectors++; if (flag_cnt !== 1) begin miscompares++; $display("FAIL vf_pulses got %0d want 1", flag_cnt); end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        base = flag_cnt;
        send_byte(8'h55);
        send_byte(8'h70);
        send_byte(8'h00);
        @(negedge sys_clk);
        vectors++; if (command_flag !== 1'b0) begin miscompares++; $display("FAIL bc_flag got %h want 0", command_flag); end
        vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL bc_err got %0d want 1", err_cnt); end
        vectors++; if (tx_data !== 8'h15) begin miscompares++; $display("FAIL bc_txd got %h want 15", tx_data); end
        vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL bc_txv got %h want 1", tx_valid); end
        @(negedge sys_clk);
        send_byte(8'h55);
        send_byte(8'h61);
        send_byte(8'h9E);
        @(negedge sys_clk);
        vectors++; if (command_flag !== 1'b1) begin miscompares++; $display("FAIL bc2_flag got %h want 1", command_flag); end
        repeat (5) @(negedge sys_clk);
        vectors++; if (ctrl_command_out !== 4'h6) begin miscompares++; $display("FAIL bc2_ctrl got %h want 6", ctrl_command_out); end
        vectors++; if (value_command_out !== 4'h1) begin miscompares++; $display("FAIL bc2_value got %h want 1", value_command_out); end
        vectors++; if (frame_ok_cnt !== 16'd1) begin miscompares++; $display("FAIL bc2_ok got %0d want 1", frame_ok_cnt); end
        vectors++; if (flag_cnt - base !== 1) begin miscompares++; $display("FAIL bc2_pulses got %0d want 1", flag_cnt - base); end
    endtask

    task automatic test_resync();
        do_reset();
        send_byte(8'h55);
        send_byte(8'h70);
        send_byte(8'h55);
        send_byte(8'h80);
        send_byte(8'h7F);
        @(negedge sys_clk);
        vectors++; if (command_flag !== 1'b1) begin miscompares++; $display("FAIL rs_flag got %h want 1", command_flag); end
        vectors++; if (ctrl_command_out !== 4'h8) begin miscompares++; $display("FAIL rs_ctrl got %h want 8", ctrl_command_out); end
        vectors++; if (value_command_out !== 4'h0) begin miscompares++; $display("FAIL rs_value got %h want 0", value_command_out); end
        vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL rs_err got %0d want 1", err_cnt); end
        vectors++; if (frame_ok_cnt !== 16'd1) begin miscompares++; $display("FAIL rs_ok got %0d want 1", frame_ok_cnt); end
        vectors++; if (tx_data !== 8'h06) begin miscompares++; $display("FAIL rs_txd got %h want 06", tx_data); end
    endtask

    task automatic test_timeout();
        do_reset();
        base = flag_cnt;
        send_byte(8'h55);
        send_byte(8'h72);
        repeat (TO) @(negedge sys_clk);
        send_byte(8'h8D);
        repeat (3) @(negedge sys_clk);
        vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL to_err got %0d want 1", err_cnt); end
        vectors++; if (flag_cnt - base !== 0) begin miscompares++; $display("FAIL to_pulses got %0d want 0", flag_cnt - base); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL to_txv got %h want 0", tx_valid); end
        vectors++; if (frame_ok_cnt !== 16'd0) begin miscompares++; $display("FAIL to_ok got %0d want 0", frame_ok_cnt); end
        send_byte(8'h55);
        send_byte(8'h72);
        repeat (TO - 1) @(negedge sys_clk);
        send_byte(8'h8D);
        @(negedge sys_clk);
        vectors++; if (command_flag !== 1'b1) begin miscompares++; $display("FAIL tob_flag got %h want 1", command_flag); end
        vectors++; if (ctrl_command_out !== 4'h7) begin miscompares++; $display("FAIL tob_ctrl got %h want 7", ctrl_command_out); end
        vectors++; if (value_command_out !== 4'h2) begin miscompares++; $display("FAIL tob_value got %h want 2", value_command_out); end
        vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL tob_err got %0d want 1", err_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        base = flag_cnt;
        tx_ready = 1'b0;
        send_byte(8'h55);
        send_byte(8'h75);
        send_byte(8'h8A);
        send_byte(8'h55);
        send_byte(8'h81);
        send_byte(8'h7E);
        repeat (3) @(negedge sys_clk);
        vectors++; if (flag_cnt - base !== 2) begin miscompares++; $display("FAIL bp_pulses got %0d want 2", flag_cnt - base); end
        vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL bp_txv got %h want 1", tx_valid); end
        vectors++; if (tx_data !== 8'h06) begin miscompares++; $display("FAIL bp_txd got %h want 06", tx_data); end
        vectors++; if (ctrl_command_out !== 4'h8) begin miscompares++; $display("FAIL bp_ctrl got %h want 8", ctrl_command_out); end
        vectors++; if (value_command_out !== 4'h1) begin miscompares++; $display("FAIL bp_value got %h want 1", value_command_out); end
        tx_ready = 1'b1;
        @(negedge sys_clk);
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL bp_txclr got %h want 0", tx_valid); end
        vectors++; if (frame_ok_cnt !== 16'd2) begin miscompares++; $display("FAIL bp_ok got %0d want 2", frame_ok_cnt); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_byte(8'h55);
        send_byte(8'h75);
        send_byte(8'h8A);
        repeat (2) @(negedge sys_clk);
        base = flag_cnt;
        send_byte(8'h55);
        send_byte(8'h75);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (ctrl_command_out !== 4'h0) begin miscompares++; $display("FAIL mr_ctrl got %h want 0", ctrl_command_out); end
        vectors++; if (value_command_out !== 4'h0) begin miscompares++; $display("FAIL mr_value got %h want 0", value_command_out); end
        vectors++; if (frame_ok_cnt !== 16'd0) begin miscompares++; $display("FAIL mr_ok got %0d want 0", frame_ok_cnt); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL mr_txd got %h want 00", tx_data); end
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        send_byte(8'h8A);
        repeat (3) @(negedge sys_clk);
        vectors++; if (flag_cnt - base !== 0) begin miscompares++; $display("FAIL mr_pulses got %0d want 0", flag_cnt - base); end
        vectors++; if (ctrl_command_out !== 4'h0) begin miscompares++; $display("FAIL mr2_ctrl got %h want 0", ctrl_command_out); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL mr2_txv got %h want 0", tx_valid); end
        vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL mr2_err got %0d want 0", err_cnt); end
        vectors++; if (frame_ok_cnt !== 16'd0) begin miscompares++; $display("FAIL mr2_ok got %0d want 0", frame_ok_cnt); end
    endtask

    task automatic test_err_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h55);
            send_byte(8'h70);
            send_byte(8'h00);
            if (i == 253) begin
                @(negedge sys_clk);
                vectors++; if (err_cnt !== 8'd254) begin miscompares++; $display("FAIL sat_254 got %0d want 254", err_cnt); end
            end
        end
        repeat (3) @(negedge sys_clk);
        vectors++; if (err_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_hold got %0d want 255", err_cnt); end
        vectors++; if (frame_ok_cnt !== 16'd0) begin miscompares++; $display("FAIL sat_ok got %0d want 0", frame_ok_cnt); end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_resync();
        test_timeout();
        test_backpressure();
        test_reset_midframe();
        test_err_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
